// File: rtl/life_pkg.sv
// Shared definitions for the life grid text frame: byte codes, encoder states
// and the frame length helper used by the encoder and the pattern loader.
package life_pkg;

    localparam logic [7:0] CHAR_ALIVE = 8'h23;
    localparam logic [7:0] CHAR_DEAD  = 8'h2E;
    localparam logic [7:0] CHAR_NL    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CELL = 2'd1,
        NL   = 2'd2
    } enc_state_t;

    // Bytes in one frame: every row carries WIDTH cells plus its newline.
    function automatic int frame_len(input int width, input int height);
        return height * (width + 1);
    endfunction

endpackage

// File: rtl/life_frame_encoder.sv
// Serialises a snapshot of the life grid into '#'/'.' bytes with a '\n' per
// row, over a valid/ready byte stream. All outputs are registered.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no frame in flight; start latches the grid and emits cell (0,0)
// CELL  | out_char holds the cell byte for (row, col) of the snapshot
// NL    | out_char holds the newline that closes the current row
module life_frame_encoder
    import life_pkg::*;
#(
    parameter int WIDTH  = 20,
    parameter int HEIGHT = 20
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [WIDTH*HEIGHT-1:0]   states,
    output logic                      busy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_char,
    output logic                      frame_done
);

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int IDX_W = (CELLS  > 1) ? $clog2(CELLS)  : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    enc_state_t         state, state_nxt;
    logic [CELLS-1:0]   snapshot, snapshot_nxt;
    logic [ROW_W-1:0]   row, row_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic               busy_nxt, valid_nxt, done_nxt;
    logic [7:0]         char_nxt;
    logic               handshake;
    logic [CELLS-1:0]   cell_src;
    logic [IDX_W-1:0]   cell_idx;
    logic               cell_bit;

    assign handshake = out_valid && out_ready;

    // Next-state logic; the byte for the next state is computed here so that
    // out_char can be registered without a bubble at row or frame boundaries.
    always_comb begin
        state_nxt    = state;
        snapshot_nxt = snapshot;
        row_nxt      = row;
        col_nxt      = col;
        busy_nxt     = busy;
        valid_nxt    = out_valid;
        done_nxt     = 1'b0;
        char_nxt     = 8'h00;
        cell_src     = snapshot;

        case (state)
            IDLE: begin
                if (start) begin
                    // The first byte comes straight from the live grid, since
                    // the snapshot is only being loaded on this same edge.
                    snapshot_nxt = states;
                    cell_src     = states;
                    row_nxt      = '0;
                    col_nxt      = '0;
                    state_nxt    = CELL;
                    busy_nxt     = 1'b1;
                    valid_nxt    = 1'b1;
                end
            end
            CELL: begin
                if (handshake) begin
                    if (col == COL_LAST) begin
                        state_nxt = NL;
                    end else begin
                        col_nxt = col + COL_W'(1);
                    end
                end
            end
            NL: begin
                if (handshake) begin
                    if (row == ROW_LAST) begin
                        state_nxt = IDLE;
                        busy_nxt  = 1'b0;
                        valid_nxt = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        row_nxt   = row + ROW_W'(1);
                        col_nxt   = '0;
                        state_nxt = CELL;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                valid_nxt = 1'b0;
            end
        endcase

        cell_idx = IDX_W'(row_nxt) * IDX_W'(WIDTH) + IDX_W'(col_nxt);
        cell_bit = cell_src[cell_idx];

        case (state_nxt)
            CELL:    char_nxt = cell_bit ? CHAR_ALIVE : CHAR_DEAD;
            NL:      char_nxt = CHAR_NL;
            default: char_nxt = 8'h00;
        endcase
    end

    // State, counters, snapshot and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            snapshot   <= '0;
            row        <= '0;
            col        <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_char   <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            snapshot   <= snapshot_nxt;
            row        <= row_nxt;
            col        <= col_nxt;
            busy       <= busy_nxt;
            out_valid  <= valid_nxt;
            out_char   <= char_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule
